tape_ear_conditioner: RTL and testbench
=======================================

TAPE_EAR_CONDITIONER -- requirements
Module: tape_ear_conditioner

Interface
REQ-001 SHALL have parameter CLK_RATE, default 28000000, meaning the clk_sys frequency in Hz; the 1 us tick period is CLK_RATE/1000000 cycles.
REQ-002 SHALL have parameter FILT_BITS, default 4, meaning the width of the glitch-filter integrator.
REQ-003 SHALL have parameter MIN_HALF_US, default 100, meaning the minimum qualifying half-period in us, inclusive.
REQ-004 SHALL have parameter MAX_HALF_US, default 2000, meaning the maximum qualifying half-period in us, inclusive.
REQ-005 SHALL have parameter ACT_EDGES, default 16, meaning the number of consecutive qualifying edges needed to lock.
REQ-006 SHALL have parameter HOLD_MS, default 500, meaning the inactivity timeout in ms (1000 ticks per ms).
REQ-007 SHALL have port clk_sys, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port adc_din, input, 1 bit: raw comparator bit from the tape ADC stage.
REQ-010 SHALL have port adc_active, input, 1 bit: ADC-stage valid flag.
REQ-011 SHALL have port ear_o, output, 1 bit: conditioned EAR level fed to the core ear input.
REQ-012 SHALL have port active_o, output, 1 bit: high while the block is in state LOCKED.
REQ-013 SHALL have port edge_o, output, 1 bit: one-cycle pulse on each filtered-level change.
REQ-014 SHALL have port period_o, output, 12 bits: last measured half-period in us, saturating at 4095.

Function
REQ-015 SHALL generate a one-cycle tick every CLK_RATE/1000000 clk_sys cycles from a free-running prescaler.
REQ-016 SHALL use sample s = adc_din & adc_active.
REQ-017 On each tick, the integrator SHALL increment if s=1 and it is below max, decrement if s=0 and it is above 0, and otherwise hold.
REQ-018 The filtered level filt SHALL set to 1 when the integrator reaches 2^FILT_BITS-1, clear to 0 when it reaches 0, and otherwise hold (hysteresis).
REQ-019 edge_o SHALL pulse for exactly one cycle, in the cycle after filt changes.
REQ-020 A half-period counter SHALL increment on each tick, saturating at 4095.
REQ-021 On a filt change, the half-period counter SHALL load period_o with its count and then restart from 0 (filt change and tick in the same cycle: the counter restarts at 0 and that tick is lost).
REQ-022 An edge SHALL be qualifying iff MIN_HALF_US <= measured count <= MAX_HALF_US.
REQ-023 The state machine SHALL have three states: IDLE, TRACK, LOCKED.
REQ-024 IDLE -> TRACK on any filt edge, with the qualified-edge count qcnt cleared to 0.
REQ-025 In TRACK, a qualifying edge SHALL increment qcnt, and TRACK -> LOCKED when qcnt reaches ACT_EDGES.
REQ-026 In TRACK, a non-qualifying edge SHALL reset qcnt to 0 and remain in TRACK.
REQ-027 In TRACK, a hold timeout SHALL return the FSM to IDLE.
REQ-028 In LOCKED, a qualifying edge SHALL reload the hold timer.
REQ-029 In LOCKED, non-qualifying edges SHALL be ignored (no state change).
REQ-030 LOCKED -> IDLE when the hold timer reaches HOLD_MS*1000 ticks without a qualifying edge.
REQ-031 The hold timer SHALL count ticks and clear on every qualifying edge and on every state change.
REQ-032 If adc_active=0, the FSM SHALL force IDLE on the next cycle; this overrides any edge in the same cycle.
REQ-033 ear_o SHALL equal filt when in LOCKED and 0 otherwise, registered with 1 cycle of latency from the state/filt update.
REQ-034 active_o SHALL be registered and high exactly while the state is LOCKED.
REQ-035 No counter SHALL wrap: the qcnt, half-period and hold counters all saturate.

Reset
REQ-036 While reset=1, the outputs SHALL be ear_o=0, active_o=0, edge_o=0, period_o=0, independent of the clock.
REQ-037 While reset=1, the prescaler, integrator, filt, qcnt, half-period counter and hold timer SHALL be 0 and the state SHALL be IDLE.
REQ-038 Reset asserted mid-operation (including from LOCKED) SHALL clear all state immediately.
REQ-039 After reset deasserts, the first tick SHALL occur CLK_RATE/1000000 cycles later.

Verification
REQ-040 Scenario 1: defaults; square wave of 500 us half-period, adc_active=1. Required: edge_o pulses each half; period_o reads 500 +/- 1 (filter delay is symmetric); active_o rises on the 16th qualifying edge; ear_o then follows the input delayed by 15 us +/- 1 tick.
REQ-041 Scenario 2: while LOCKED, inject 5 us low glitches. Required: filt, edge_o and ear_o do not change.
REQ-042 Scenario 3: 15 edges at 500 us, then one at 50 us, then 16 edges at 500 us. Required: qcnt resets at the 50 us edge; active_o rises only on the 16th edge after it; 100 us and 2000 us half-periods qualify, 99 us and 2001 us do not.
REQ-043 Scenario 4: signal stops while LOCKED. Required: active_o and ear_o fall 500 ms +/- 1 ms after the last qualifying edge; period_o stays at 4095 once the count saturates.
REQ-044 Scenario 5: drop adc_active for 1 cycle while LOCKED. Required: IDLE on the next cycle; active_o=0; the integrator decays to 0 over 15 ticks.
REQ-045 Scenario 6: assert reset asynchronously between clock edges while LOCKED. Required: all outputs 0 before the next clock edge; after release, the first tick comes 28 cycles later.

Source files
------------

// File: rtl/tape_ear_conditioner_if.sv
// Signal bundle between the tape ADC front end and the EAR conditioner.
// The ADC side drives the sample and valid flag; the conditioner returns the cleaned EAR level and status.
interface tape_ear_conditioner_if;
    logic        adc_din;
    logic        adc_active;
    logic        ear_o;
    logic        active_o;
    logic        edge_o;
    logic [11:0] period_o;

    modport master (
        output adc_din, adc_active,
        input  ear_o, active_o, edge_o, period_o
    );

    modport slave (
        input  adc_din, adc_active,
        output ear_o, active_o, edge_o, period_o
    );
endinterface

// File: rtl/tape_ear_conditioner.sv
// Tape EAR conditioner: glitch-filters the ADC comparator bit and measures its half-periods.
// It only passes the level through to the core once a run of plausible tape edges has been seen.
//
// state  | meaning
// IDLE   | no tape signal; ear output forced low
// TRACK  | edges seen, counting consecutive qualifying half-periods
// LOCKED | tape signal accepted; ear follows the filtered level
module tape_ear_conditioner #(
    parameter int CLK_RATE    = 28000000,
    parameter int FILT_BITS   = 4,
    parameter int MIN_HALF_US = 100,
    parameter int MAX_HALF_US = 2000,
    parameter int ACT_EDGES   = 16,
    parameter int HOLD_MS     = 500
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    tape_ear_conditioner_if.slave  bus
);
    localparam int DIV        = CLK_RATE / 1000000;
    localparam int PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_TICKS = HOLD_MS * 1000;
    localparam int HW         = $clog2(HOLD_TICKS + 1);
    localparam int QW         = $clog2(ACT_EDGES + 1);

    localparam logic [FILT_BITS-1:0] INT_MAX = '1;
    localparam logic [11:0]          MIN_C   = 12'(MIN_HALF_US);
    localparam logic [11:0]          MAX_C   = 12'(MAX_HALF_US);
    localparam logic [HW-1:0]        HOLD_C  = HW'(HOLD_TICKS);
    localparam logic [QW-1:0]        ACT_C   = QW'(ACT_EDGES);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        pre_cnt;
    logic                 tick;
    logic [FILT_BITS-1:0] integ, integ_nxt;
    logic                 filt, filt_nxt, filt_chg;
    logic                 s;
    logic [11:0]          hp_cnt, period_q;
    logic [HW-1:0]        hold_cnt;
    logic                 timeout;
    logic [QW-1:0]        qcnt, qcnt_nxt;
    logic                 qual;
    logic                 edge_q, active_q, ear_q;

    assign tick    = (pre_cnt == PW'(DIV - 1));
    assign s       = bus.adc_din & bus.adc_active;
    assign timeout = (hold_cnt == HOLD_C);
    assign qual    = filt_chg && (hp_cnt >= MIN_C) && (hp_cnt <= MAX_C);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // filt is derived from the next integrator value so both update on the same tick
    always_comb begin
        integ_nxt = integ;
        if (tick) begin
            if (s && integ != INT_MAX)      integ_nxt = integ + 1'b1;
            else if (!s && integ != '0)     integ_nxt = integ - 1'b1;
        end
        filt_nxt = filt;
        if (integ_nxt == INT_MAX)   filt_nxt = 1'b1;
        else if (integ_nxt == '0)   filt_nxt = 1'b0;
        filt_chg = (filt_nxt != filt);
    end

    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        case (state)
            IDLE: begin
                if (filt_chg) begin
                    state_nxt = TRACK;
                    qcnt_nxt  = '0;
                end
            end
            TRACK: begin
                if (qual) begin
                    if (qcnt != ACT_C) qcnt_nxt = qcnt + 1'b1;
                    if (qcnt_nxt == ACT_C) state_nxt = LOCKED;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end else if (filt_chg) begin
                    qcnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (!qual && timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.adc_active) begin
            state_nxt = IDLE;
            qcnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            integ    <= '0;
            filt     <= 1'b0;
            qcnt     <= '0;
            hp_cnt   <= '0;
            period_q <= '0;
            hold_cnt <= '0;
            edge_q   <= 1'b0;
            active_q <= 1'b0;
            ear_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            integ <= integ_nxt;
            filt  <= filt_nxt;
            qcnt  <= qcnt_nxt;
            // a level change swallows a coincident tick: the new half-period starts at 0
            if (filt_chg) begin
                period_q <= hp_cnt;
                hp_cnt   <= '0;
            end else if (tick && hp_cnt != 12'hFFF) begin
                hp_cnt <= hp_cnt + 1'b1;
            end
            if (qual || state_nxt != state)  hold_cnt <= '0;
            else if (tick && !timeout)       hold_cnt <= hold_cnt + 1'b1;
            edge_q   <= filt_chg;
            active_q <= (state_nxt == LOCKED);
            ear_q    <= (state == LOCKED) && filt;
        end
    end

    assign bus.ear_o    = ear_q;
    assign bus.active_o = active_q;
    assign bus.edge_o   = edge_q;
    assign bus.period_o = period_q;
endmodule

// File: tb/tb_tape_ear_conditioner.sv
// Directed bench for tape_ear_conditioner using scaled-down parameters.
// 2 cycles per tick, 2-bit filter (3 ticks of delay), window 10..40, lock after 4 edges, 1000-tick hold.
// A level held for H ticks is measured as H-1, because the tick at each level change is dropped.
module tb_tape_ear_conditioner;
    localparam int CLK_RATE = 2000000;
    localparam int DIV      = 2;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   edge_cnt = 0;
    int   last_edge_cyc = 0;
    int   run = 0;
    int   max_run = 0;

    tape_ear_conditioner_if bus ();

    tape_ear_conditioner #(
        .CLK_RATE(CLK_RATE), .FILT_BITS(2), .MIN_HALF_US(10), .MAX_HALF_US(40),
        .ACT_EDGES(4), .HOLD_MS(1)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (bus.edge_o === 1'b1) begin
            edge_cnt++;
            last_edge_cyc = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    // called at a negedge; holds the input for exactly h ticks and returns at a negedge
    task automatic half(input logic lvl, input int h);
        bus.adc_din = lvl;
        repeat (2 * h) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        bus.adc_din = 1'b0;
        bus.adc_active = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic lock_default();
        for (int i = 0; i < 5; i++) half((i % 2) == 0, 21);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        bus.adc_din = 1'b0;
        bus.adc_active = 1'b1;
        #1;
        chk("reset_ear", int'(bus.ear_o), 0);
        chk("reset_active", int'(bus.active_o), 0);
        chk("reset_edge", int'(bus.edge_o), 0);
        chk("reset_period", int'(bus.period_o), 0);
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("idle_ear", int'(bus.ear_o), 0);
        chk("idle_edge_cnt", edge_cnt, 0);
    endtask

    task automatic test_lock();
        int e0, d;
        e0 = edge_cnt;
        for (int i = 0; i < 4; i++) half((i % 2) == 0, 21);
        chk("lock_active_e4", int'(bus.active_o), 0);
        half(1'b1, 21);
        chk("lock_active_e5", int'(bus.active_o), 1);
        chk("lock_period", int'(bus.period_o), 20);
        chk("lock_ear_high", int'(bus.ear_o), 1);
        chk("lock_edge_cnt", edge_cnt - e0, 5);
        chk("edge_width", max_run, 1);
        bus.adc_din = 1'b0;
        d = 0;
        while (bus.ear_o === 1'b1 && d < 60) begin
            @(negedge clk_sys);
            d++;
        end
        checks++;
        if (d < 5 || d > 9) begin
            errors++;
            $display("FAIL ear_delay: got %0d cycles expected 5..9", d);
        end
        repeat (42 - d) @(negedge clk_sys);
        chk("lock_ear_low", int'(bus.ear_o), 0);
        chk("lock_period2", int'(bus.period_o), 20);
    endtask

    task automatic test_glitch();
        int e0, lows;
        half(1'b1, 10);
        e0 = edge_cnt;
        chk("glitch_pre_ear", int'(bus.ear_o), 1);
        lows = 0;
        bus.adc_din = 1'b0;
        repeat (4) begin
            @(negedge clk_sys);
            if (bus.ear_o !== 1'b1) lows++;
        end
        bus.adc_din = 1'b1;
        repeat (20) begin
            @(negedge clk_sys);
            if (bus.ear_o !== 1'b1) lows++;
        end
        chk("glitch_ear_low_samples", lows, 0);
        chk("glitch_edges", edge_cnt - e0, 0);
        half(1'b0, 21);
        chk("glitch_period", int'(bus.period_o), 21);
        chk("glitch_active", int'(bus.active_o), 1);
    endtask

    task automatic test_qualify();
        int seq[13] = '{21, 21, 21, 10, 21, 21, 21, 42, 21, 21, 21, 21, 21};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            half((i % 2) == 0, seq[i]);
            if (i == 4) begin
                chk("short_period", int'(bus.period_o), 9);
                chk("short_resets_qcnt", int'(bus.active_o), 0);
            end
            if (i == 8) begin
                chk("long_period", int'(bus.period_o), 41);
                chk("long_resets_qcnt", int'(bus.active_o), 0);
            end
            if (i == 11) chk("relock_e3", int'(bus.active_o), 0);
        end
        chk("relock_e4", int'(bus.active_o), 1);
    endtask

    task automatic test_timeout();
        int n, d;
        chk("timeout_pre_ear", int'(bus.ear_o), 1);
        n = 0;
        while (bus.active_o === 1'b1 && n < 4000) begin
            @(negedge clk_sys);
            n++;
        end
        d = cyc - last_edge_cyc;
        checks++;
        if (bus.active_o !== 1'b0 || d < 1998 || d > 2003) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles active=%0d expected 1998..2003 active=0",
                     d, bus.active_o);
        end
        repeat (2) @(negedge clk_sys);
        chk("timeout_ear", int'(bus.ear_o), 0);
    endtask

    task automatic test_saturation();
        int n;
        n = 0;
        while ((cyc - last_edge_cyc) < 8400 && n < 9000) begin
            @(negedge clk_sys);
            n++;
        end
        half(1'b0, 10);
        chk("period_saturates", int'(bus.period_o), 4095);
        half(1'b1, 10);
        chk("period_restart", int'(bus.period_o), 9);
    endtask

    task automatic test_boundaries();
        do_reset();
        for (int i = 0; i < 4; i++) half((i % 2) == 0, 41);
        half(1'b1, 21);
        chk("max_edge_period", int'(bus.period_o), 40);
        chk("max_edge_locks", int'(bus.active_o), 1);
        do_reset();
        for (int i = 0; i < 4; i++) half((i % 2) == 0, 11);
        half(1'b1, 21);
        chk("min_edge_period", int'(bus.period_o), 10);
        chk("min_edge_locks", int'(bus.active_o), 1);
    endtask

    task automatic test_adc_drop();
        int n;
        do_reset();
        lock_default();
        chk("drop_pre_active", int'(bus.active_o), 1);
        bus.adc_active = 1'b0;
        @(negedge clk_sys);
        chk("drop_active", int'(bus.active_o), 0);
        bus.adc_active = 1'b1;
        @(negedge clk_sys);
        chk("drop_ear", int'(bus.ear_o), 0);
        repeat (20) @(negedge clk_sys);
        chk("drop_stays_idle", int'(bus.active_o), 0);
        bus.adc_active = 1'b0;
        n = 0;
        while (bus.edge_o !== 1'b1 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (n < 4 || n > 7) begin
            errors++;
            $display("FAIL decay_delay: got %0d cycles expected 4..7", n);
        end
        bus.adc_active = 1'b1;
        bus.adc_din = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        lock_default();
        chk("areset_pre_active", int'(bus.active_o), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_active", int'(bus.active_o), 0);
        chk("areset_ear", int'(bus.ear_o), 0);
        chk("areset_edge", int'(bus.edge_o), 0);
        chk("areset_period", int'(bus.period_o), 0);
        bus.adc_din = 1'b1;
        bus.adc_active = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        n = 0;
        while (bus.edge_o !== 1'b1 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("first_tick_after_reset", n, 3 * DIV);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_qualify();
        test_timeout();
        test_saturation();
        test_boundaries();
        test_adc_drop();
        test_async_reset();
        chk("edge_width_final", max_run, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
